modulation_gen_v3: RTL and testbench

Parametrised multi-state square-wave modulation generator for the FOG loop. It produces a 2-state (±bias) or 4-state modulation waveform with per-state amplitudes and a programmable dwell per state. Configuration is applied glitch-free, only at modulation-cycle boundaries. It also emits a step trigger and a cycle-start strobe for the demodulator and ramp logic, and accepts a synchronous phase-restart input.

---
 rtl/modulation_gen_v3.sv | 120 ++++++++++++
 tb/tb_modulation_gen_v3.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/modulation_gen_v3.sv
// Square-wave modulation generator for the FOG loop: 2- or 4-state waveform with
// per-state amplitude and dwell; configuration swaps only at cycle boundaries.
//
// state | meaning
// S0    | first half / first quarter, cycle start
// S1    | second state, last state in 2-state mode
// S2    | third state (4-state only)
// S3    | fourth state, last state in 4-state mode
module modulation_gen_v3 #(
    parameter int OUTPUT_BIT = 32,
    parameter int CNT_BIT    = 32,
    parameter int RESET_CNT  = 100
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_en,
    input  logic                         i_sync,
    input  logic                         i_mode,
    input  logic        [CNT_BIT-1:0]    i_freq_cnt,
    input  logic signed [OUTPUT_BIT-1:0] i_amp_0,
    input  logic signed [OUTPUT_BIT-1:0] i_amp_1,
    input  logic signed [OUTPUT_BIT-1:0] i_amp_2,
    input  logic signed [OUTPUT_BIT-1:0] i_amp_3,
    output logic signed [OUTPUT_BIT-1:0] o_mod_out,
    output logic                         o_status,
    output logic        [1:0]            o_state,
    output logic                         o_stepTrig,
    output logic                         o_cycle_start
);

    typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_e;

    localparam logic [CNT_BIT-1:0] CNT_RST = CNT_BIT'(RESET_CNT);
    localparam logic [CNT_BIT-1:0] CNT_ONE = CNT_BIT'(1);

    state_e                 st_q, st_d;
    logic [CNT_BIT-1:0]     cnt_q, cnt_d;
    logic [CNT_BIT-1:0]     act_freq_q;
    logic signed [OUTPUT_BIT-1:0] act_amp_q [4];
    logic signed [OUTPUT_BIT-1:0] amp_in [4];
    logic                   act_mode_q;
    logic                   wrap_q, wrap_d;
    logic                   status_prev_q;
    logic                   last_st;
    logic                   reload;

    assign amp_in[0] = i_amp_0;
    assign amp_in[1] = i_amp_1;
    assign amp_in[2] = i_amp_2;
    assign amp_in[3] = i_amp_3;

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        reload  = 1'b0;
        wrap_d  = 1'b0;
        last_st = act_mode_q ? (st_q == S3) : (st_q == S1);
        if (!i_en) begin
            st_d   = S0;
            cnt_d  = i_freq_cnt;
            reload = 1'b1;
        end else if (i_sync) begin
            st_d   = S0;
            cnt_d  = i_freq_cnt;
            reload = 1'b1;
            wrap_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end else if (last_st) begin
            // cycle boundary: the freshly loaded dwell applies to the new S0
            st_d   = S0;
            cnt_d  = i_freq_cnt;
            reload = 1'b1;
            wrap_d = 1'b1;
        end else begin
            st_d  = state_e'(st_q + 2'd1);
            cnt_d = act_freq_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_q       <= S0;
            cnt_q      <= CNT_RST;
            act_freq_q <= CNT_RST;
            act_mode_q <= 1'b0;
            wrap_q     <= 1'b0;
            for (int i = 0; i < 4; i++) act_amp_q[i] <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            if (reload) begin
                act_freq_q <= i_freq_cnt;
                act_mode_q <= i_mode;
                for (int i = 0; i < 4; i++) act_amp_q[i] <= amp_in[i];
            end
        end
    end

    // Output stage lags st by one clock; amplitude already reflects any reload
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mod_out     <= '0;
            o_state       <= 2'd0;
            o_status      <= 1'b0;
            status_prev_q <= 1'b0;
            o_stepTrig    <= 1'b0;
            o_cycle_start <= 1'b0;
        end else begin
            o_mod_out     <= act_amp_q[st_q];
            o_state       <= st_q;
            o_status      <= st_q[0];
            status_prev_q <= o_status;
            o_stepTrig    <= o_status ^ status_prev_q;
            o_cycle_start <= wrap_q;
        end
    end

endmodule

// File: tb/tb_modulation_gen_v3.sv
// Scoreboard bench for modulation_gen_v3: a behavioural model predicts each output
// cycle into a queue, and a negedge monitor pops and compares.
module tb_modulation_gen_v3;
    localparam int OB = 32;
    localparam int CB = 32;
    localparam int RC = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, sync = 1'b0, mode = 1'b0;
    logic [CB-1:0] freq = '0;
    logic signed [OB-1:0] a0 = '0, a1 = '0, a2 = '0, a3 = '0;
    logic signed [OB-1:0] mod_out;
    logic status, step_trig, cycle_start;
    logic [1:0] state;

    always #5 clk = ~clk;

    modulation_gen_v3 #(.OUTPUT_BIT(OB), .CNT_BIT(CB), .RESET_CNT(RC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sync(sync), .i_mode(mode),
        .i_freq_cnt(freq), .i_amp_0(a0), .i_amp_1(a1), .i_amp_2(a2), .i_amp_3(a3),
        .o_mod_out(mod_out), .o_status(status), .o_state(state),
        .o_stepTrig(step_trig), .o_cycle_start(cycle_start)
    );

    typedef struct {
        logic signed [OB-1:0] mod;
        logic [1:0]           st;
        logic                 stat;
        logic                 step;
        logic                 cs;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int errors = 0;
    int checks = 0;

    // Behavioural model: state index, clocks spent in it, its length, active config
    logic [1:0] m_st;
    longint m_age, m_dwell;
    longint c_freq;
    logic signed [OB-1:0] c_amp [4];
    logic c_mode;
    logic m_wrap;
    logic e_stat, e_stat_prev;

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endfunction

    task automatic model_reset();
        m_st = 2'd0; m_age = 0; m_dwell = RC + 1; c_freq = RC; c_mode = 1'b0;
        for (int i = 0; i < 4; i++) c_amp[i] = '0;
        m_wrap = 1'b0; e_stat = 1'b0; e_stat_prev = 1'b0;
    endtask

    task automatic model_clock();
        exp_t e;
        bit ending, boundary;
        logic [1:0] last_st;
        e.mod  = c_amp[m_st];
        e.st   = m_st;
        e.stat = m_st[0];
        e.step = (e_stat != e_stat_prev);
        e.cs   = m_wrap;
        e_stat_prev = e_stat;
        e_stat = e.stat;
        last_st  = c_mode ? 2'd3 : 2'd1;
        ending   = (m_age == m_dwell - 1);
        boundary = en && ending && (m_st == last_st);
        m_wrap   = en && (sync || boundary);
        if (!en || sync || boundary) begin
            c_freq = longint'(freq); c_mode = mode;
            c_amp[0] = a0; c_amp[1] = a1; c_amp[2] = a2; c_amp[3] = a3;
            m_st = 2'd0; m_age = 0; m_dwell = c_freq + 1;
        end else if (!ending) begin
            m_age++;
        end else begin
            m_st = m_st + 2'd1; m_age = 0; m_dwell = c_freq + 1;
        end
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_st(logic [1:0] s);
        for (int i = 0; i < 400 && m_st != s; i++) tick();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mod", longint'(mod_out), 0);
        chk("async_rst_state", longint'(state), 0);
        chk("async_rst_status", longint'(status), 0);
        chk("async_rst_step", longint'(step_trig), 0);
        chk("async_rst_cs", longint'(cycle_start), 0);
        model_reset();
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("mod_out", longint'(mod_out), longint'(me.mod));
            chk("state", longint'(state), longint'(me.st));
            chk("status", longint'(status), longint'(me.stat));
            chk("stepTrig", longint'(step_trig), longint'(me.step));
            chk("cycle_start", longint'(cycle_start), longint'(me.cs));
        end
    end

    initial begin
        model_reset();
        #2;
        chk("reset_mod", longint'(mod_out), 0);
        chk("reset_state", longint'(state), 0);
        chk("reset_status", longint'(status), 0);
        chk("reset_cs", longint'(cycle_start), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2-state, RESET_CNT dwell before the first boundary
        en = 1'b1; mode = 1'b0; freq = 3; a0 = -1000; a1 = 1000; a2 = 7; a3 = -7;
        ticks(260);

        // 4-state, 2 clocks per state
        mode = 1'b1; freq = 1; a0 = -300; a1 = 100; a2 = 300; a3 = -100;
        ticks(40);

        // config change mid-S1 must not disturb the running cycle
        wait_st(2'd1);
        a1 = 555; freq = 5;
        ticks(40);

        // 1-clock dwell, then mode switch
        freq = 0; mode = 1'b0;
        ticks(30);
        mode = 1'b1;
        ticks(20);

        // phase restart during S2
        freq = 4;
        ticks(12);
        wait_st(2'd2);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        ticks(30);

        // disable during S1, re-enable after 10 clocks, then reset mid-S3
        wait_st(2'd1);
        en = 1'b0;
        ticks(10);
        en = 1'b1;
        ticks(25);
        wait_st(2'd3);
        do_reset();
        ticks(250);

        // randomized stretch
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) freq = CB'($urandom_range(0, 4));
            if ($urandom_range(0, 19) == 0) begin
                a0 = $urandom; a1 = $urandom; a2 = $urandom; a3 = $urandom;
            end
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            if ($urandom_range(0, 59) == 0) en = ~en;
            sync = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1499) == 0) do_reset();
            tick();
        end
        sync = 1'b0;
        #1;
        chk("queue_drained", longint'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
